mem_access_unit: RTL and testbench

- Memory-stage request sequencer sitting directly upstream of the load extraction datapath.
- Accepts one load/store per transaction from EX/MEM and generates the word-aligned memory request: address, byte enables and lane-replicated store data.
- Waits for the memory response, then hands the raw 32-bit word, byte address and load type to the load extraction stage.
- Single outstanding transaction.

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/mem_access_unit_if.sv | 43 ++++
 rtl/mem_access_unit_store_lane_gen.sv | 33 +++
 rtl/mem_access_unit.sv | 129 ++++++++++++
 tb/tb_mem_access_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg : shared funct3/ld_type encodings, FSM states, decode helpers    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic type_illegal(input logic is_store, input logic [2:0] f3);
        logic ill;
        if (is_store) ill = (f3 >= 3'b011);
        else          ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        return ill;
    endfunction

    function automatic logic [2:0] ld_type_map(input logic [2:0] f3);
        logic [2:0] t;
        case (f3)
            F3_BU:   t = LD_LBU;
            F3_HU:   t = LD_LHU;
            F3_H:    t = LD_LH;
            F3_W:    t = LD_LW;
            default: t = LD_LB;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit_if : request, memory bus and load-hand-off signals       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        ld_valid;
    logic [2:0]  ld_type;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        st_done;
    logic        err;

    // The unit itself is the slave; the pipeline/memory environment is the master.
    modport slave (
        input  req_valid, req_is_store, req_type, req_addr, req_wdata,
               mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output req_ready, mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
               ld_valid, ld_type, ld_addr, ld_data, st_done, err
    );

    modport master (
        output req_valid, req_is_store, req_type, req_addr, req_wdata,
               mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  req_ready, mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
               ld_valid, ld_type, ld_addr, ld_data, st_done, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_store_lane_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_lane_gen : byte enables and lane-replicated data for a store       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module store_lane_gen
    import mem_pkg::*;
(
    input  wire logic [2:0]  st_type,
    input  wire logic [1:0]  addr_lo,
    input  wire logic [31:0] wdata,
    output logic      [3:0]  be,
    output logic      [31:0] lane_wdata
);

    always_comb begin
        be         = 4'b1111;
        lane_wdata = wdata;
        case (st_type)
            F3_B: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            F3_H: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit : single-outstanding load/store memory request sequencer |
// | Option MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of align.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES       = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] RESET_PC_UNUSED_ADDR = 32'h0000_0000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_access_unit_if.slave  bus
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] req_addr_aligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    always_comb begin
        req_addr_aligned = bus.req_addr;
        if (bus.req_type[1:0] == 2'b01)  req_addr_aligned[0]   = 1'b0;
        else if (bus.req_type == F3_W)   req_addr_aligned[1:0] = 2'b00;
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    is_store_d = bus.req_is_store;
                    f3_d       = bus.req_type;
                    addr_d     = req_addr_aligned;
                    wdata_d    = bus.req_wdata;
`ifdef MEM_MISALIGN_TRAP_EN
                    err_d      = type_illegal(bus.req_is_store, bus.req_type) ||
                                 (req_addr_aligned != bus.req_addr);
`else
                    err_d      = type_illegal(bus.req_is_store, bus.req_type);
`endif
                    state_d    = err_d ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.mem_req_ready) begin
                    cnt_d   = 8'd0;
                    state_d = is_store_q ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A response in the timeout cycle still completes the load.
                if (bus.mem_rsp_valid) begin
                    rdata_d = bus.mem_rsp_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q + 8'd1 == C_TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= RESET_PC_UNUSED_ADDR;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    store_lane_gen u_store_lane_gen (
        .st_type    (f3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .be         (lane_be),
        .lane_wdata (lane_wdata)
    );

    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.mem_req_valid = (state_q == ST_REQ);
    assign bus.mem_addr      = {addr_q[31:2], 2'b00};
    assign bus.mem_we        = (state_q == ST_REQ) && is_store_q;
    assign bus.mem_be        = (state_q != ST_REQ) ? 4'b0000 : (is_store_q ? lane_be : 4'b1111);
    assign bus.mem_wdata     = ((state_q == ST_REQ) && is_store_q) ? lane_wdata : 32'h0;
    assign bus.ld_valid      = (state_q == ST_DONE) && !err_q && !is_store_q;
    assign bus.ld_type       = ld_type_map(f3_q);
    assign bus.ld_addr       = addr_q;
    assign bus.ld_data       = rdata_q;
    assign bus.st_done       = (state_q == ST_DONE) && !err_q && is_store_q;
    assign bus.err           = (state_q == ST_DONE) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_unit : directed and random checks against a txn model      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_access_unit;

    localparam int TMO = 4;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_access_unit_if bus();

    mem_access_unit #(
        .TIMEOUT_CYCLES       (TMO),
        .RESET_PC_UNUSED_ADDR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes implied by funct3.
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 1;
        endcase
    endfunction

    function automatic bit legal_type(input bit st, input logic [2:0] f3);
        if (st) return f3 <= 3'd2;
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic logic [2:0] exp_ld_type(input logic [2:0] f3);
        case (f3)
            3'b100:  return 3'b011;
            3'b101:  return 3'b100;
            default: return f3;
        endcase
    endfunction

    task automatic run_txn(input string tag, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int req_lat, input int rsp_lat, input logic [31:0] rd);
        int          sz;
        int          last;
        logic [31:0] fa;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        bit          eerr;
        sz   = size_of(f3);
        fa   = a - (a % sz);
        eerr = !legal_type(st, f3) || (TRAP && ((a % sz) != 0));
        ebe  = st ? 4'(((1 << sz) - 1) << (fa % 4)) : 4'hF;
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % sz) +: 8];

        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL %s idle_ready: got=%b want=1", tag, bus.req_ready);
        end
        bus.req_valid = 1'b1; bus.req_is_store = st; bus.req_type = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        tick();
        bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
        bus.req_type = 3'($urandom); bus.req_is_store = 1'($urandom);

        if (eerr) begin
            total++;
            if ({bus.err, bus.mem_req_valid, bus.ld_valid, bus.st_done} !== 4'b1000) begin
                bad++; $display("FAIL %s err_pulse: err/mreq/ld/st got=%b%b%b%b want=1000",
                                tag, bus.err, bus.mem_req_valid, bus.ld_valid, bus.st_done);
            end
            tick();
        end else begin
            for (int i = 0; i <= req_lat; i++) begin
                bus.mem_req_ready = (i == req_lat);
                total++;
                if (bus.mem_req_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                    bus.mem_addr !== {fa[31:2], 2'b00} || bus.mem_we !== st ||
                    bus.mem_be !== ebe || (st && bus.mem_wdata !== ewd)) begin
                    bad++;
                    $display("FAIL %s req[%0d]: v=%b rdy=%b addr=%h we=%b be=%b wd=%h want v=1 rdy=0 addr=%h we=%b be=%b wd=%h",
                             tag, i, bus.mem_req_valid, bus.req_ready, bus.mem_addr, bus.mem_we,
                             bus.mem_be, bus.mem_wdata, {fa[31:2], 2'b00}, st, ebe, ewd);
                end
                tick();
            end
            bus.mem_req_ready = 1'b0;
            if (st) begin
                total++;
                if ({bus.st_done, bus.err, bus.ld_valid, bus.mem_req_valid} !== 4'b1000) begin
                    bad++; $display("FAIL %s st_done: st/err/ld/mreq got=%b%b%b%b want=1000",
                                    tag, bus.st_done, bus.err, bus.ld_valid, bus.mem_req_valid);
                end
                tick();
            end else begin
                last = (rsp_lat < TMO) ? rsp_lat : TMO - 1;
                for (int w = 0; w <= last; w++) begin
                    bus.mem_rsp_valid = (w == rsp_lat);
                    bus.mem_rsp_rdata = (w == rsp_lat) ? rd : $urandom;
                    total++;
                    if ({bus.ld_valid, bus.err, bus.mem_req_valid, bus.req_ready} !== 4'b0000) begin
                        bad++; $display("FAIL %s wait[%0d]: ld/err/mreq/rdy got=%b%b%b%b want=0000",
                                        tag, w, bus.ld_valid, bus.err, bus.mem_req_valid, bus.req_ready);
                    end
                    tick();
                end
                bus.mem_rsp_valid = 1'b0;
                total++;
                if (rsp_lat < TMO) begin
                    if (bus.ld_valid !== 1'b1 || bus.err !== 1'b0 || bus.ld_data !== rd ||
                        bus.ld_type !== exp_ld_type(f3) || bus.ld_addr !== fa) begin
                        bad++;
                        $display("FAIL %s load_done: ld=%b err=%b data=%h type=%b addr=%h want ld=1 err=0 data=%h type=%b addr=%h",
                                 tag, bus.ld_valid, bus.err, bus.ld_data, bus.ld_type, bus.ld_addr,
                                 rd, exp_ld_type(f3), fa);
                    end
                end else begin
                    if (bus.err !== 1'b1 || bus.ld_valid !== 1'b0) begin
                        bad++; $display("FAIL %s timeout: err=%b ld=%b want err=1 ld=0",
                                        tag, bus.err, bus.ld_valid);
                    end
                end
                tick();
            end
        end
        total++;
        if ({bus.req_ready, bus.ld_valid, bus.st_done, bus.err, bus.mem_req_valid} !== 5'b10000) begin
            bad++; $display("FAIL %s back_idle: rdy/ld/st/err/mreq got=%b%b%b%b%b want=10000",
                            tag, bus.req_ready, bus.ld_valid, bus.st_done, bus.err, bus.mem_req_valid);
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        total++;
        if (bus.req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.mem_addr !== 32'h0 ||
            bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0 || bus.mem_wdata !== 32'h0 ||
            bus.ld_valid !== 1'b0 || bus.ld_type !== 3'h0 || bus.ld_addr !== 32'h0 ||
            bus.ld_data !== 32'h0 || bus.st_done !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b mreq=%b addr=%h we=%b be=%b wd=%h ld=%b lt=%b la=%h ldd=%h st=%b err=%b want rdy=1 rest 0",
                     bus.req_ready, bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata,
                     bus.ld_valid, bus.ld_type, bus.ld_addr, bus.ld_data, bus.st_done, bus.err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_store_byte();
        run_txn("sb_1003", 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0);
        run_txn("sw_2000", 1'b1, 3'b010, 32'h0000_2000, 32'hCAFE_F00D, 1, 0, 32'h0);
    endtask

    task automatic test_load_hu();
        run_txn("lhu_2002", 1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 0, 32'hBEEF_1234);
    endtask

    task automatic test_stall();
        run_txn("lw_stall", 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5, 1, 32'h1357_9BDF);
    endtask

    task automatic test_timeout();
        run_txn("lw_tmo", 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 100, 32'h0);
        run_txn("lw_edge", 1'b0, 3'b010, 32'h0000_0104, 32'h0, 0, TMO - 1, 32'h5A5A_A5A5);
    endtask

    task automatic test_misalign();
        run_txn("sh_3001", 1'b1, 3'b001, 32'h0000_3001, 32'h0000_BEEF, 0, 0, 32'h0);
        run_txn("lw_3006", 1'b0, 3'b010, 32'h0000_3006, 32'h0, 0, 0, 32'h0BAD_CAFE);
    endtask

    task automatic test_illegal();
        run_txn("st_011", 1'b1, 3'b011, 32'h0000_4000, 32'h1234_5678, 0, 0, 32'h0);
        run_txn("ld_110", 1'b0, 3'b110, 32'h0000_4000, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic test_wait_reset();
        bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_type = 3'b010;
        bus.req_addr = 32'h0000_0080;
        tick();
        bus.req_valid = 1'b0; bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.ld_valid !== 1'b0) begin
            bad++; $display("FAIL wait_reset_async: rdy=%b mreq=%b ld=%b want 1 0 0",
                            bus.req_ready, bus.mem_req_valid, bus.ld_valid);
        end
        tick();
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (bus.ld_valid !== 1'b0 || bus.err !== 1'b0 || bus.req_ready !== 1'b1 ||
                bus.ld_data !== 32'h0) begin
                bad++; $display("FAIL late_rsp[%0d]: ld=%b err=%b rdy=%b data=%h want 0 0 1 0",
                                i, bus.ld_valid, bus.err, bus.req_ready, bus.ld_data);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = cyc;
        for (int i = 0; i < 3; i++)
            run_txn("b2b_lw", 1'b0, 3'b010, 32'h100 + 32'(4 * i), 32'h0, 0, 0, $urandom);
        total++;
        if (cyc - start !== 12) begin
            bad++; $display("FAIL b2b_cycles: got=%0d want=12", cyc - start);
        end
    endtask

    task automatic test_random();
        logic [2:0] f3;
        bit         st;
        for (int n = 0; n < 40; n++) begin
            st = 1'($urandom);
            if ($urandom_range(9) == 0) f3 = 3'($urandom);
            else if (st)                f3 = 3'($urandom_range(2));
            else                        f3 = ($urandom_range(4) > 2) ? 3'($urandom_range(5, 4))
                                                                      : 3'($urandom_range(2));
            run_txn("rand", st, f3, $urandom, $urandom, $urandom_range(3),
                    $urandom_range(TMO + 1), $urandom);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_type = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = 32'h0;
        test_reset();
        test_store_byte();
        test_load_hu();
        test_stall();
        test_timeout();
        test_misalign();
        test_illegal();
        test_wait_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
